// File: rtl/sw_seq_ctrl_pkg.sv
// rtl/sw_seq_ctrl_pkg.sv - shared Smith-Waterman constants and sequencer state encoding
package sw_seq_ctrl_pkg;

    // Systolic array geometry and field widths
    localparam int SW_PE_N  = 64;
    localparam int SW_SYM_W = 2;
    localparam int SW_LEN_W = 16;
    localparam int SW_RES_W = 16;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_T = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/sw_seq_ctrl.sv
// rtl/sw_seq_ctrl.sv - job sequencer: loads T into the datapath, streams S chunks, captures the score
module sw_seq_ctrl
    import sw_seq_ctrl_pkg::*;
#(
    parameter int PE_N  = SW_PE_N,
    parameter int SYM_W = SW_SYM_W,
    parameter int S_AW  = 8,
    parameter int T_AW  = 10,
    parameter int T_DW  = 18,
    parameter int LEN_W = SW_LEN_W,
    parameter int RES_W = SW_RES_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_start,
    input  logic [LEN_W-1:0]         job_s_len,
    input  logic [T_AW:0]            job_t_words,
    output logic                     job_busy,
    output logic                     job_done,
    output logic                     job_err,
    output logic [RES_W-1:0]         job_score,
    output logic [T_AW-1:0]          t_rd_addr,
    input  logic [T_DW-1:0]          t_rd_data,
    output logic                     s_rd_en,
    output logic [S_AW-1:0]          s_rd_addr,
    input  logic [PE_N*SYM_W-1:0]    s_rd_data,
    output logic                     dp_set_t,
    output logic [T_DW-1:0]          dp_t,
    output logic                     dp_start_cal,
    input  logic                     dp_busy,
    input  logic                     dp_req_s,
    output logic [PE_N*SYM_W-1:0]    dp_s,
    output logic [$clog2(PE_N):0]    dp_s_valid,
    input  logic [RES_W-1:0]         dp_result,
    input  logic                     dp_res_valid
);

    localparam int VW = $clog2(PE_N) + 1;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] s_len_q, s_len_d;
    logic [T_AW:0]    t_words_q, t_words_d;
    logic [T_AW:0]    t_cnt_q, t_cnt_d;
    logic             t_vld_q, t_vld_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [S_AW-1:0]  ptr_q, ptr_d;
    logic             infl_q, infl_d;
    logic [RES_W-1:0] score_q, score_d;
    logic             err_q, err_d;
    logic             done_first_q, done_first_d;

    logic             issue;
    logic [VW-1:0]    chunk_n;

    // Symbols carried by the chunk currently presented: a full word or the tail of S
    assign chunk_n = (rem_q > LEN_W'(PE_N)) ? VW'(PE_N) : VW'(rem_q);

    // A new S read goes out only when the datapath asks, nothing is pending and no score is arriving
    assign issue = (state_q == ST_RUN) && dp_req_s && !infl_q && !dp_res_valid;

    // Next-state logic for the job FSM, the T loader and the S streamer
    always_comb begin
        state_d      = state_q;
        s_len_d      = s_len_q;
        t_words_d    = t_words_q;
        t_cnt_d      = t_cnt_q;
        t_vld_d      = 1'b0;
        rem_d        = rem_q;
        ptr_d        = ptr_q;
        infl_d       = issue;
        score_d      = score_q;
        err_d        = 1'b0;
        done_first_d = 1'b0;

        // Chunk presented this cycle: advance through S, wrapping to its start for the next T pass
        if (infl_q) begin
            if (rem_q > LEN_W'(PE_N)) begin
                rem_d = rem_q - LEN_W'(PE_N);
                ptr_d = ptr_q + 1'b1;
            end else begin
                rem_d = s_len_q;
                ptr_d = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (job_start) begin
                    if ((job_s_len != '0) && (job_t_words != '0)) begin
                        s_len_d   = job_s_len;
                        t_words_d = job_t_words;
                        rem_d     = job_s_len;
                        ptr_d     = '0;
                        t_cnt_d   = '0;
                        state_d   = ST_LOAD_T;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_T: begin
                if (t_cnt_q < t_words_q) begin
                    t_cnt_d = t_cnt_q + 1'b1;
                    t_vld_d = 1'b1;
                end
                if (t_vld_q && (t_cnt_q == t_words_q)) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dp_res_valid) begin
                    score_d      = dp_result;
                    done_first_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!dp_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any job and drops a pending chunk
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_len_q      <= '0;
            t_words_q    <= '0;
            t_cnt_q      <= '0;
            t_vld_q      <= 1'b0;
            rem_q        <= '0;
            ptr_q        <= '0;
            infl_q       <= 1'b0;
            score_q      <= '0;
            err_q        <= 1'b0;
            done_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_len_q      <= s_len_d;
            t_words_q    <= t_words_d;
            t_cnt_q      <= t_cnt_d;
            t_vld_q      <= t_vld_d;
            rem_q        <= rem_d;
            ptr_q        <= ptr_d;
            infl_q       <= infl_d;
            score_q      <= score_d;
            err_q        <= err_d;
            done_first_q <= done_first_d;
        end
    end

    assign job_busy     = (state_q != ST_IDLE);
    assign job_done     = (state_q == ST_DONE) && done_first_q;
    assign job_err      = err_q;
    assign job_score    = score_q;

    assign t_rd_addr    = t_cnt_q[T_AW-1:0];
    assign dp_set_t     = (state_q == ST_LOAD_T) && (t_cnt_q == '0) && !t_vld_q;
    assign dp_t         = t_vld_q ? t_rd_data : '0;
    assign dp_start_cal = (state_q == ST_START);

    assign s_rd_en      = issue;
    assign s_rd_addr    = ptr_q;
    assign dp_s         = infl_q ? s_rd_data : '0;
    assign dp_s_valid   = infl_q ? chunk_n : '0;

endmodule

// File: tb/tb_sw_seq_ctrl.sv
// tb/tb_sw_seq_ctrl.sv - scoreboard bench for the Smith-Waterman job sequencer
module tb_sw_seq_ctrl;

    localparam int PE_N  = 64;
    localparam int SYM_W = 2;
    localparam int S_AW  = 8;
    localparam int T_AW  = 10;
    localparam int T_DW  = 18;
    localparam int LEN_W = 16;
    localparam int RES_W = 16;
    localparam int SDW   = PE_N * SYM_W;
    localparam int VW    = $clog2(PE_N) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 job_start;
    logic [LEN_W-1:0]     job_s_len;
    logic [T_AW:0]        job_t_words;
    logic                 job_busy, job_done, job_err;
    logic [RES_W-1:0]     job_score;
    logic [T_AW-1:0]      t_rd_addr;
    logic [T_DW-1:0]      t_rd_data;
    logic                 s_rd_en;
    logic [S_AW-1:0]      s_rd_addr;
    logic [SDW-1:0]       s_rd_data;
    logic                 dp_set_t;
    logic [T_DW-1:0]      dp_t;
    logic                 dp_start_cal;
    logic                 dp_busy;
    logic                 dp_req_s;
    logic [SDW-1:0]       dp_s;
    logic [VW-1:0]        dp_s_valid;
    logic [RES_W-1:0]     dp_result;
    logic                 dp_res_valid;

    sw_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .job_start(job_start), .job_s_len(job_s_len), .job_t_words(job_t_words),
        .job_busy(job_busy), .job_done(job_done), .job_err(job_err), .job_score(job_score),
        .t_rd_addr(t_rd_addr), .t_rd_data(t_rd_data),
        .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
        .dp_set_t(dp_set_t), .dp_t(dp_t), .dp_start_cal(dp_start_cal),
        .dp_busy(dp_busy), .dp_req_s(dp_req_s), .dp_s(dp_s), .dp_s_valid(dp_s_valid),
        .dp_result(dp_result), .dp_res_valid(dp_res_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_set_t = 0, n_start = 0, n_done = 0, n_err = 0, n_srd = 0;
    int t_first = -1, t_last = -1;
    int chunk_cyc[$];

    logic [S_AW-1:0]     exp_addr[$];
    logic [VW+SDW-1:0]   exp_chunk[$];
    logic [T_DW-1:0]     exp_t[$];
    logic [T_DW-1:0]     tmem[0:15];

    function automatic logic [SDW-1:0] s_word(input logic [S_AW-1:0] a);
        return {8{a, ~a}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory models: one-cycle read latency
    always @(posedge clk) begin
        t_rd_data <= tmem[t_rd_addr[3:0]];
        if (s_rd_en) s_rd_data <= s_word(s_rd_addr);
    end

    // Monitor: pops expectations whenever the DUT presents something
    always @(negedge clk) begin
        cyc++;
        if (dp_set_t)     n_set_t++;
        if (dp_start_cal) n_start++;
        if (job_done)     n_done++;
        if (job_err)      n_err++;
        if (dp_t != '0) begin
            if (t_first < 0) t_first = cyc;
            t_last = cyc;
            if (exp_t.size() == 0) chk("unexpected_dp_t", 256'(dp_t), 256'(0));
            else chk("dp_t", 256'(dp_t), 256'(exp_t.pop_front()));
        end
        if (s_rd_en) begin
            n_srd++;
            if (exp_addr.size() == 0) chk("unexpected_s_rd", 256'(s_rd_addr), 256'hdead);
            else chk("s_rd_addr", 256'(s_rd_addr), 256'(exp_addr.pop_front()));
        end
        if (dp_s_valid != '0) begin
            chunk_cyc.push_back(cyc);
            if (exp_chunk.size() == 0) chk("unexpected_chunk", 256'(dp_s_valid), 256'(0));
            else chk("chunk", 256'({dp_s_valid, dp_s}), 256'(exp_chunk.pop_front()));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_chunk(input logic [S_AW-1:0] a, input int v, input bit delivered);
        exp_addr.push_back(a);
        if (delivered) exp_chunk.push_back({VW'(v), s_word(a)});
    endtask

    task automatic start_job(input int slen, input int tw);
        int k;
        int s0;
        s0 = n_set_t;
        for (int i = 0; i < tw; i++) exp_t.push_back(tmem[i]);
        t_first = -1;
        job_start = 1'b1; job_s_len = LEN_W'(slen); job_t_words = (T_AW+1)'(tw);
        tick;
        job_start = 1'b0;
        k = 0;
        while (!dp_start_cal && k < 40) begin tick; k++; end
        chk("start_cal_seen", 256'(k < 40), 256'(1));
        tick;
        chk("set_t_pulses", 256'(n_set_t - s0), 256'(1));
        chk("dp_t_consecutive", 256'(t_last - t_first), 256'(tw - 1));
    endtask

    task automatic req_once;
        dp_req_s = 1'b1; tick;
        dp_req_s = 1'b0; tick;
    endtask

    task automatic end_job(input logic [RES_W-1:0] res, input int busy_cycles);
        int d0;
        d0 = n_done;
        dp_busy = 1'b1; dp_result = res; dp_res_valid = 1'b1;
        tick;
        dp_res_valid = 1'b0; dp_result = '0;
        chk("done_pulse", 256'(job_done), 256'(1));
        repeat (busy_cycles) tick;
        chk("busy_in_done", 256'({job_busy, job_done}), 256'(2'b10));
        dp_busy = 1'b0;
        tick;
        chk("idle_after_done", 256'(job_busy), 256'(0));
        chk("job_score", 256'(job_score), 256'(res));
        chk("done_count", 256'(n_done - d0), 256'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int s0, e0, st0;
        for (int i = 0; i < 16; i++) tmem[i] = T_DW'(18'h2A000 + i * 7 + 1);
        rst = 1'b1; job_start = 1'b0; job_s_len = '0; job_t_words = '0;
        dp_busy = 1'b0; dp_req_s = 1'b0; dp_result = '0; dp_res_valid = 1'b0;
        repeat (3) tick;
        chk("reset_outputs", 256'({job_busy, job_done, job_err, job_score, s_rd_en,
                                   dp_set_t, dp_t, dp_start_cal, dp_s, dp_s_valid}), 256'(0));
        rst = 1'b0;
        tick;

        // 150 symbols over 4 T words: chunks 64,64,22
        st0 = n_start;
        start_job(150, 4);
        chk("start_cal_pulses", 256'(n_start - st0), 256'(1));
        push_chunk(0, 64, 1); req_once;
        push_chunk(1, 64, 1); req_once;
        push_chunk(2, 22, 1); req_once;
        end_job(16'h0055, 1);

        // Exact multiple of PE_N wraps back to word 0 each time
        start_job(64, 1);
        push_chunk(0, 64, 1); req_once;
        push_chunk(0, 64, 1); req_once;
        push_chunk(0, 64, 1); req_once;
        end_job(16'h0102, 2);

        // Zero lengths are rejected without touching memory
        s0 = n_srd; e0 = n_err;
        job_start = 1'b1; job_s_len = 16'd0; job_t_words = 11'd4;
        tick;
        job_start = 1'b0;
        chk("err_slen0", 256'({job_err, job_busy}), 256'(2'b10));
        tick;
        chk("err_clear", 256'({job_err, job_busy}), 256'(0));
        job_start = 1'b1; job_s_len = 16'd10; job_t_words = 11'd0;
        tick;
        job_start = 1'b0;
        chk("err_twords0", 256'({job_err, job_busy}), 256'(2'b10));
        repeat (3) tick;
        chk("err_count", 256'(n_err - e0), 256'(2));
        chk("no_reads_on_err", 256'({n_srd - s0, job_busy, dp_set_t}), 256'(0));

        // Request held high: one chunk every other cycle
        start_job(300, 2);
        chunk_cyc.delete();
        push_chunk(0, 64, 1); push_chunk(1, 64, 1); push_chunk(2, 64, 1);
        push_chunk(3, 64, 1); push_chunk(4, 44, 1);
        dp_req_s = 1'b1;
        repeat (10) tick;
        dp_req_s = 1'b0;
        tick;
        chk("held_chunk_count", 256'(chunk_cyc.size()), 256'(5));
        for (int i = 1; i < chunk_cyc.size(); i++)
            chk("held_chunk_gap", 256'(chunk_cyc[i] - chunk_cyc[i-1]), 256'(2));
        end_job(16'h0777, 1);

        // Score arrives while a chunk is in flight
        start_job(150, 2);
        push_chunk(0, 64, 1);
        dp_busy = 1'b1;
        dp_req_s = 1'b1;
        tick;
        dp_res_valid = 1'b1; dp_result = 16'h01A3;
        tick;
        dp_res_valid = 1'b0; dp_result = '0; dp_req_s = 1'b0;
        chk("res_done_pulse", 256'({job_done, job_busy}), 256'(2'b11));
        repeat (2) tick;
        chk("res_hold_done", 256'({job_done, job_busy}), 256'(2'b01));
        dp_busy = 1'b0;
        tick;
        chk("res_idle", 256'(job_busy), 256'(0));
        chk("res_score", 256'(job_score), 256'(16'h01A3));

        // Reset mid-run with a read in flight, then a fresh job starts at S word 0
        start_job(150, 1);
        push_chunk(0, 64, 1); req_once;
        push_chunk(1, 64, 1); req_once;
        push_chunk(2, 22, 0);
        dp_req_s = 1'b1; rst = 1'b1;
        tick;
        dp_req_s = 1'b0; rst = 1'b0;
        chk("rst_outputs", 256'({job_busy, job_done, job_err, job_score, s_rd_en,
                                 dp_set_t, dp_t, dp_start_cal, dp_s, dp_s_valid}), 256'(0));
        tick;
        start_job(150, 1);
        push_chunk(0, 64, 1); req_once;
        end_job(16'h0009, 1);

        repeat (2) tick;
        chk("exp_t_drained", 256'(exp_t.size()), 256'(0));
        chk("exp_addr_drained", 256'(exp_addr.size()), 256'(0));
        chk("exp_chunk_drained", 256'(exp_chunk.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_seq_ctrl.md
SW_SEQ_CTRL -- requirements
Module: sw_seq_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): PE_N, 64, symbols per S word; SYM_W, 2, bits per symbol; S_AW, 8, S memory address width; T_AW, 10, T memory address width; T_DW, 18, T memory word width; LEN_W, 16, length field width; RES_W, 16, score width.
REQ-002 SHALL have ports: clk, in, 1, sole clock, rising edge.
REQ-003 rst, in, 1, reset, synchronous, active-high.
REQ-004 job_start, in, 1, start-job pulse; job_s_len, in, LEN_W, S length in symbols; job_t_words, in, T_AW+1, T word count.
REQ-005 job_busy, out, 1, job in progress; job_done, out, 1, one-cycle completion pulse; job_err, out, 1, one-cycle reject pulse; job_score, out, RES_W, last captured score.
REQ-006 t_rd_addr, out, T_AW, T memory address; t_rd_data, in, T_DW, T read data, valid one cycle after address.
REQ-007 s_rd_en, out, 1, S read strobe; s_rd_addr, out, S_AW, S word address; s_rd_data, in, PE_N*SYM_W, S read data, valid one cycle after s_rd_en.
REQ-008 dp_set_t, out, 1; dp_t, out, T_DW; dp_start_cal, out, 1; dp_busy, in, 1; dp_req_s, in, 1; dp_s, out, PE_N*SYM_W; dp_s_valid, out, log2(PE_N)+1; dp_result, in, RES_W; dp_res_valid, in, 1.

Function
REQ-009 SHALL implement FSM IDLE -> LOAD_T -> START -> RUN -> DONE -> IDLE.
REQ-010 IDLE: job_start with job_s_len != 0 and job_t_words != 0 SHALL latch both lengths and enter LOAD_T next cycle; either length zero SHALL pulse job_err for one cycle and stay in IDLE.
REQ-011 job_start outside IDLE SHALL be ignored.
REQ-012 LOAD_T: dp_set_t SHALL be high on the first LOAD_T cycle only; t_rd_addr SHALL step 0..job_t_words-1, one per cycle; dp_t SHALL present t_rd_data one cycle after each address, zero otherwise.
REQ-013 LOAD_T SHALL exit to START the cycle after the last T word is presented on dp_t; START SHALL pulse dp_start_cal for exactly one cycle, then enter RUN.
REQ-014 RUN: when dp_req_s is high and no chunk is in flight, the block SHALL assert s_rd_en with s_rd_addr = current word pointer and mark a chunk in flight.
REQ-015 The cycle after s_rd_en, dp_s SHALL carry s_rd_data and dp_s_valid = min(remaining, PE_N); dp_s and dp_s_valid SHALL be zero on every other cycle; the in-flight flag SHALL clear in that same cycle.
REQ-016 Throughput: at most one chunk per 2 cycles; dp_req_s held high SHALL yield chunks on alternate cycles.
REQ-017 After a chunk, remaining > PE_N SHALL decrement remaining by PE_N and increment the pointer; remaining <= PE_N SHALL reload remaining = job_s_len and pointer = 0 (wrap for next T pass).
REQ-018 Pointer SHALL wrap modulo 2^S_AW without error.
REQ-019 RUN: dp_res_valid SHALL capture dp_result into job_score and enter DONE; a chunk in flight on that cycle SHALL still be presented, and no new read SHALL issue.
REQ-020 dp_res_valid in any state other than RUN SHALL be ignored.
REQ-021 DONE: job_done SHALL pulse for one cycle; FSM SHALL return to IDLE once dp_busy is low, holding DONE otherwise with job_done low after the first cycle.
REQ-022 job_busy SHALL be high in every state except IDLE.
REQ-023 dp_req_s outside RUN SHALL be ignored.

Reset
REQ-024 rst SHALL force IDLE; all outputs zero, including job_score, pointer, remaining, in-flight flag; applies identically mid-job, discarding any in-flight chunk.

Structure
REQ-025 PE_N, SYM_W, RES_W, LEN_W and the FSM state encoding SHALL live in the shared Smith-Waterman package; no sub-module is required; FSM and S streamer SHALL reside in one module.

Verification
REQ-026 s_len=150, t_words=4, dp_req_s pulsed thrice -> dp_set_t one cycle, dp_t = mem T[0..3] on 4 consecutive cycles, dp_start_cal one pulse, chunks addr 0,1,2 with dp_s_valid 64,64,22.
REQ-027 s_len=64, three requests -> addresses 0,0,0, dp_s_valid 64 each (exact-multiple wrap).
REQ-028 s_len=0 or t_words=0 -> job_err one cycle, job_busy stays 0, no memory reads.
REQ-029 dp_req_s held high 10 cycles in RUN, s_len=300 -> 5 chunks on alternate cycles, valid 64,64,64,64,44.
REQ-030 dp_res_valid with result 0x01A3 while chunk in flight -> chunk still delivered, job_score=0x01A3, job_done one pulse, IDLE after dp_busy falls.
REQ-031 rst asserted in RUN with chunk in flight -> next cycle all outputs zero, IDLE; new job then restarts at S address 0.
